// File: rtl/usb_tx_data_buffer.sv
// usb_tx_data_buffer: 64-byte first-word-fall-through FIFO that stages bulk-IN
// payload bytes between the AHB-Lite slave (pushes) and the USB transmitter
// (pops). The head byte is visible combinationally so the transmitter can
// consume it in the same cycle it asserts its pop strobe.
//
// Handshake: a push is a single-cycle strobe (store_tx_data) with no ready.
// It is accepted when the buffer is not full, or when it is full and a valid
// pop lands in the same cycle. A refused push sets overrun_err. A pop
// (get_tx_packet_data) is valid only when the buffer is non-empty; a pop while
// empty changes no state and sets underrun_err. clear overrides both strobes.
module usb_tx_data_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              store_tx_data,
  input  logic [7:0]        tx_data,
  input  logic              get_tx_packet_data,
  output logic [7:0]        tx_packet_data,
  output logic [ADDR_W:0]   buffer_occupancy,
  output logic              buffer_empty,
  output logic              buffer_full,
  output logic              overrun_err,
  output logic              underrun_err
);

  localparam logic [ADDR_W:0] full_count = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count;
  logic              pop_ok;
  logic              push_ok;

  // Status is decoded from the occupancy counter, never from pointer equality.
  assign buffer_empty     = (count == '0);
  assign buffer_full      = (count == full_count);
  assign buffer_occupancy = count;

  // A full buffer can still take a byte when the head leaves in the same cycle.
  always_comb begin
    pop_ok  = get_tx_packet_data && !buffer_empty;
    push_ok = store_tx_data && (!buffer_full || pop_ok);
  end

  // Fall-through head byte; zero when nothing is stored.
  always_comb begin
    tx_packet_data = 8'h00;
    if (!buffer_empty) begin
      tx_packet_data = mem[rptr];
    end
  end

  // Byte storage has no reset and is left untouched by clear.
  always_ff @(posedge clk) begin
    if (!clear && push_ok) begin
      mem[wptr] <= tx_data;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      overrun_err  <= 1'b0;
      underrun_err <= 1'b0;
    end else if (clear) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      overrun_err  <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
      if (store_tx_data && !push_ok) begin
        overrun_err <= 1'b1;
      end
      if (get_tx_packet_data && buffer_empty) begin
        underrun_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/usb_tx_data_buffer.md
# usb_tx_data_buffer

A 64-byte first-word-fall-through FIFO that stages outgoing bulk-IN payload bytes between the AHB-Lite slave interface and the USB transmitter. The AHB side pushes bytes with `store_tx_data`. The transmitter pops bytes with `get_tx_packet_data` and reads the head byte on `tx_packet_data`. `buffer_occupancy` drives the transmitter's `tx_packet_size`.

## Interface
- `DEPTH`, 64, number of byte entries; must be a power of two.
- `ADDR_W`, 6, pointer width, equal to log2(DEPTH).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush; has priority over all other inputs.
- `store_tx_data`  in  1  push strobe; one byte per cycle while high.
- `tx_data`  in  8  byte to push, sampled with `store_tx_data`.
- `get_tx_packet_data`  in  1  pop strobe from the transmitter; one byte per cycle while high.
- `tx_packet_data`  out  8  head byte, first-word-fall-through; 8'h00 when empty.
- `buffer_occupancy`  out  7  stored byte count, 0..64.
- `buffer_empty`  out  1  high when occupancy is 0.
- `buffer_full`  out  1  high when occupancy is 64.
- `overrun_err`  out  1  sticky; set by a push refused because the buffer is full.
- `underrun_err`  out  1  sticky; set by a pop while empty.

## Operation
- **Storage:** DEPTH x 8 register array, write pointer `wptr`, read pointer `rptr`, each ADDR_W bits, plus a 7-bit occupancy counter. Full and empty are decoded from the counter, never from pointer equality.
- **Push:**
  - Accepted if not full, or if full and a valid pop occurs in the same cycle.
  - On accept: `mem[wptr] <= tx_data`, and `wptr` increments, wrapping 63 -> 0.
  - A refused push leaves storage unchanged and sets `overrun_err`.
- **Pop:**
  - Valid only if not empty. On a valid pop, `rptr` increments, wrapping 63 -> 0.
  - A pop while empty sets `underrun_err` and changes no state, even if a push happens in the same cycle. That push is still accepted.
- **Occupancy:**
  - Accepted push with no valid pop: +1.
  - Valid pop with no accepted push: -1.
  - Both, or neither: unchanged.
  - The counter never exceeds 64 and never goes below 0.
- **Head output:** `tx_packet_data` is combinational `mem[rptr]` when not empty, and 8'h00 when empty. The transmitter samples it in the same cycle it asserts `get_tx_packet_data`.
- **clear:**
  - Next edge: `wptr`, `rptr` and occupancy go to 0, and both error flags go to 0.
  - Memory contents are not cleared.
  - Push and pop in the same cycle as `clear` are ignored, and set no error flag.
- **Error flags:** stay set until `clear` or reset.

## Timing
- **Reset:** all pointers, the counter and the error flags are 0, so `buffer_empty`=1, `buffer_full`=0, `buffer_occupancy`=0 and `tx_packet_data`=8'h00. Memory is not reset.
- **Push to visible:** a byte pushed at edge N into an empty buffer appears on `tx_packet_data` after edge N, so it is poppable in cycle N+1.
- **Pop to next head:** after a pop at edge N, the next head byte (or 8'h00) is visible after edge N.
- **Status outputs:** `buffer_occupancy`, `buffer_full` and `buffer_empty` reflect the edge-N update immediately after edge N.
- **Throughput:** sustained one push and one pop per cycle indefinitely, with no bubbles.
- **Reset mid-operation:** asserting `n_rst` drives all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
- **Reset and fill-drain:** after reset, push 0x01..0x40 over 64 cycles, giving `buffer_full`=1 and occupancy=64. Then pop 64 times; `tx_packet_data` must read 0x01..0x40 in order, ending with `buffer_empty`=1 and `tx_packet_data`=0x00.
- **Wrap-around:** push 40 bytes, pop 40, then push 0xA0..0xBF (32 bytes). The pops must return 0xA0..0xBF in order, with occupancy stepping 32 -> 0.
- **Simultaneous push and pop:**
  - At full, push 0xEE while popping: occupancy stays 64, `overrun_err`=0, and 0xEE is the last byte read out.
  - At empty, push and pop together: occupancy becomes 1 and `underrun_err`=1.
- **Errors:**
  - Push at full with no pop: occupancy stays 64, `overrun_err`=1, and contents are intact.
  - Pop when empty: `underrun_err`=1.
  - Both flags hold until `clear`.
- **clear mid-stream:** at occupancy 17, assert `clear` together with push and pop. Next cycle: occupancy=0, `buffer_empty`=1, both error flags 0. A new push 0x55 then reads back as 0x55.
- **Async reset mid-operation:** at occupancy 10, pulse `n_rst` low between clock edges. Outputs must drop to reset values before the next edge and stay there until `n_rst` deasserts.
